// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one external loadable up/down counter among NREQ requesters.
// Each grant loads the counter with the requester's length, counts it to zero and pulses done.
//
// state | meaning
// IDLE  | counter held clear, arbitrating from pointer p
// LOAD  | grant registered, counter loaded with captured length
// RUN   | counter counting down (or reloaded with itself while hold)
// DONE  | one-cycle done pulse, counter cleared, pointer advanced

module counter_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              ctr_ld,
    output logic              ctr_clr,
    output logic              ctr_mode,
    output logic [W-1:0]      ctr_din,
    input  logic [W-1:0]      ctr_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   g_q;
    logic [PW-1:0]   g_inc;
    logic [PW-1:0]   sel;
    logic            found;
    logic [W-1:0]    len_q;

    // first requester at or after p, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    assign g_inc = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_nx = state;
        ctr_ld   = 1'b0;
        ctr_clr  = 1'b0;
        ctr_din  = '0;
        case (state)
            IDLE: begin
                ctr_clr = 1'b1;
                if (found) state_nx = LOAD;
            end
            LOAD: begin
                if (!req[g_q]) begin
                    state_nx = IDLE;
                end else if (len_q == '0) begin
                    state_nx = DONE;
                end else begin
                    ctr_ld   = 1'b1;
                    ctr_din  = len_q;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // abandon beats hold, hold beats completion
                if (!req[g_q]) begin
                    state_nx = IDLE;
                end else if (hold) begin
                    ctr_ld  = 1'b1;
                    ctr_din = ctr_out;
                end else if (ctr_out == W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                ctr_clr  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ctr_mode = 1'b0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            p_q   <= '0;
            g_q   <= '0;
            gnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                g_q   <= sel;
                gnt   <= NREQ'(1) << sel;
                len_q <= len[int'(sel)*W +: W];
            end
            if (state != IDLE && state_nx == IDLE) begin
                gnt <= '0;
                p_q <= g_inc;
            end
        end
    end

endmodule
